fft_stage3: RTL

//  Final stage of the 8-point pipelined FFT; directly downstream of fft_stage2.

---
 rtl/fft_stage3_pkg.sv | 10 +
 rtl/fft_stage3_if.sv | 17 +
 rtl/fft_stage3_bf_final.sv | 23 ++
 rtl/fft_stage3.sv | 62 ++++++
 4 files changed

// File: rtl/fft_stage3_pkg.sv
// fft_stage3_pkg: widths, FSM states and bin reordering shared by the final FFT stage
package fft_stage3_pkg;
  localparam int N = 4;
  localparam int W = 2**N;
  localparam int OW = W + 1;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction
endpackage

// File: rtl/fft_stage3_if.sv
// fft_stage3_if: stage-2 frame input and natural-order bin stream of the final FFT stage
interface fft_stage3_if;
  import fft_stage3_pkg::*;
  logic signed [W-1:0] t0, t2, t4, t6, tr1, ti1, tr3, ti3, tr5, ti5, tr7, ti7;
  logic in_valid, in_ready;
  logic signed [OW-1:0] out_re, out_im;
  logic [2:0] out_idx;
  logic out_last, out_valid, out_ready;
  modport master(
    output t0, t2, t4, t6, tr1, ti1, tr3, ti3, tr5, ti5, tr7, ti7, in_valid, out_ready,
    input in_ready, out_re, out_im, out_idx, out_last, out_valid
  );
  modport slave(
    input t0, t2, t4, t6, tr1, ti1, tr3, ti3, tr5, ti5, tr7, ti7, in_valid, out_ready,
    output in_ready, out_re, out_im, out_idx, out_last, out_valid
  );
endinterface

// File: rtl/fft_stage3_bf_final.sv
// fft_stage3_bf_final: combinational radix-2 complex butterfly, W-bit in, W+1-bit out
module fft_stage3_bf_final
  import fft_stage3_pkg::*;
(
  input  logic signed [W-1:0]  ar,
  input  logic signed [W-1:0]  ai,
  input  logic signed [W-1:0]  br,
  input  logic signed [W-1:0]  bi,
  output logic signed [OW-1:0] sr,
  output logic signed [OW-1:0] si,
  output logic signed [OW-1:0] dr,
  output logic signed [OW-1:0] di
);
  logic signed [OW-1:0] xr, xi, yr, yi;
  assign xr = ar;
  assign xi = ai;
  assign yr = br;
  assign yi = bi;
  assign sr = xr + yr;
  assign si = xi + yi;
  assign dr = xr - yr;
  assign di = xi - yi;
endmodule

// File: rtl/fft_stage3.sv
// fft_stage3: last four butterflies of the 8-point FFT, streamed out in natural bin order
module fft_stage3
  import fft_stage3_pkg::*;
(
  input logic clk,
  input logic rst,
  fft_stage3_if.slave io
);
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic signed [OW-1:0] re_q [8];
  logic signed [OW-1:0] im_q [8];
  logic signed [OW-1:0] re_d [8];
  logic signed [OW-1:0] im_d [8];
  logic signed [OW-1:0] bre [8];
  logic signed [OW-1:0] bim [8];
  logic signed [W-1:0] ar [4];
  logic signed [W-1:0] br [4];
  logic signed [W-1:0] bi [4];
  logic stream, beat, last_beat, accept;
  assign ar = '{io.t0, io.t2, io.t4, io.t6};
  assign br = '{io.tr1, io.tr3, io.tr5, io.tr7};
  assign bi = '{io.ti1, io.ti3, io.ti5, io.ti7};
  // buffer slot 2p holds pair p's sum, 2p+1 its difference; bin k lives at slot bitrev(k)
  for (genvar p = 0; p < 4; p++) begin : g_bf
    fft_stage3_bf_final u_bf (
      .ar(ar[p]), .ai('0), .br(br[p]), .bi(bi[p]),
      .sr(bre[2*p]), .si(bim[2*p]), .dr(bre[2*p+1]), .di(bim[2*p+1])
    );
  end
  always_comb begin
    stream = state_q == STREAM;
    beat = stream & io.out_ready;
    last_beat = beat & (idx_q == 3'd7);
    io.in_ready = !stream | last_beat;
    accept = io.in_valid & io.in_ready;
    state_d = accept ? STREAM : last_beat ? IDLE : state_q;
    idx_d = accept ? 3'd0 : beat ? idx_q + 3'd1 : idx_q;
    for (int k = 0; k < 8; k++) begin
      re_d[k] = accept ? bre[k] : re_q[k];
      im_d[k] = accept ? bim[k] : im_q[k];
    end
    io.out_valid = stream;
    io.out_idx = idx_q;
    io.out_last = stream & (idx_q == 3'd7);
    io.out_re = stream ? re_q[bitrev3(idx_q)] : '0;
    io.out_im = stream ? im_q[bitrev3(idx_q)] : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      re_q <= '{default: '0};
      im_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      re_q <= re_d;
      im_q <= im_d;
    end
  end
endmodule
